sort_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-entry x 4-bit bubble-sort engine between two requesters. It accepts packed unsorted vectors over valid/ready. It loads the engine, waits for completion or times out, and returns the sorted vector to the granted requester over valid/ready. It sits between the two client blocks and the sort engine, and is the only block that drives the engine's load.

---
 rtl/sort_arbiter.sv | 138 +++++++++++++
 tb/tb_sort_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sort_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sort_arbiter
// Purpose  : Round-robin sharing of one 8x4-bit sort engine between two
//            requesters, with completion timeout and registered response.
// Revision : 1.0
// ============================================================================
module sort_arbiter #(
    parameter int N       = 8,
    parameter int W       = 4,
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N*W-1:0] req0_data,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N*W-1:0] req1_data,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [N*W-1:0] rsp_data,
    output logic           rsp_err,
    output logic           sort_load,
    output logic [N*W-1:0] sort_data,
    input  logic           sort_done,
    input  logic [N*W-1:0] sort_result,
    output logic           busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_grant;
    logic          r_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_accept;
    logic          w_grant_id;
    logic          w_timeout;
    logic          w_rsp_taken;

    assign busy        = (r_state != ST_IDLE);
    assign w_timeout   = (r_cnt == C_CNT_LAST);
    assign w_rsp_taken = r_grant ? rsp1_ready : rsp0_ready;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        sort_load    = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        // A lone requester wins outright; the pointer only breaks ties.
        w_grant_id   = (req0_valid && req1_valid) ? r_ptr : !req0_valid;
        case (r_state)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    w_accept     = 1'b1;
                    req0_ready   = !w_grant_id;
                    req1_ready   = w_grant_id;
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sort_load    = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (sort_done || w_timeout) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp0_valid = !r_grant;
                rsp1_valid = r_grant;
                if (w_rsp_taken) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant   <= 1'b0;
            r_ptr     <= 1'b0;
            r_cnt     <= '0;
            sort_data <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                sort_data <= w_grant_id ? req1_data : req0_data;
                r_grant   <= w_grant_id;
                r_ptr     <= !w_grant_id;
            end
            if (r_state == ST_LOAD) begin
                r_cnt <= '0;
            end
            if (r_state == ST_WAIT) begin
                // Completion takes precedence over a coincident timeout.
                if (sort_done) begin
                    rsp_data <= sort_result;
                    rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sort_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_arbiter
// Purpose  : Directed/randomized bench for sort_arbiter with an engine model.
// Revision : 1.0
// ============================================================================
module tb_sort_arbiter;

    localparam int N       = 8;
    localparam int W       = 4;
    localparam int TIMEOUT = 64;
    localparam int CW      = 7;

    logic          clk;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]   req0_data, req1_data;
    logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0]   rsp_data;
    logic          rsp_err, sort_load, busy;
    logic [31:0]   sort_data;
    logic          sort_done = 1'b0;
    logic [31:0]   sort_result = '0;

    int n_pass  = 0;
    int n_total = 0;
    int eng_lat = 0;
    int eng_cnt = 0;
    int ptr     = 0;
    logic [31:0] eng_res;

    sort_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .sort_load(sort_load), .sort_data(sort_data),
        .sort_done(sort_done), .sort_result(sort_result),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ascending order by counting occurrences of each value.
    function automatic logic [31:0] sorted(input logic [31:0] v);
        logic [31:0] r;
        int k;
        r = '0;
        k = 0;
        for (int val = 0; val < 16; val++)
            for (int i = 0; i < N; i++)
                if (v[i*W +: W] == 4'(val)) begin
                    r[k*W +: W] = 4'(val);
                    k++;
                end
        return r;
    endfunction

    // Round-robin reference: tie goes to ptr, ptr then moves past the winner.
    function automatic int pick();
        int g;
        g   = (req0_valid && req1_valid) ? ptr : (req0_valid ? 0 : 1);
        ptr = 1 - g;
        return g;
    endfunction

    // Engine model: done pulse eng_lat cycles after the load cycle (0 = never).
    always @(negedge clk) begin
        sort_done = 1'b0;
        sort_result = $urandom;
        if (!rst) begin
            eng_cnt = 0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    sort_done   = 1'b1;
                    sort_result = eng_res;
                end
            end
            if (sort_load) begin
                eng_res = sorted(sort_data);
                eng_cnt = eng_lat;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic serve(input int g, input int lat, input bit exp_err,
                         input bit keep, input int bp);
        logic [31:0] d, exp_d;
        logic [1:0]  gv;
        int n;
        gv      = (g == 1) ? 2'b10 : 2'b01;
        d       = (g == 1) ? req1_data : req0_data;
        exp_d   = exp_err ? 32'h0 : sorted(d);
        eng_lat = lat;
        #1 check("grant_ready", {req1_ready, req0_ready}, gv);
        @(negedge clk);
        if (g == 1) begin
            req1_valid = keep;
            req1_data  = $urandom;
            if (bp > 0) begin req0_valid = 1'b1; req0_data = $urandom; end
        end else begin
            req0_valid = keep;
            req0_data  = $urandom;
            if (bp > 0) begin req1_valid = 1'b1; req1_data = $urandom; end
        end
        #1 check("load_pulse", {sort_load, busy, req1_ready, req0_ready}, 4'b1100);
        check("sort_data", sort_data, d);
        @(negedge clk);
        #1 check("load_once", sort_load, 0);
        n = 1;
        while (!(rsp0_valid || rsp1_valid) && n < 200) begin
            @(negedge clk);
            #1 n++;
        end
        check("rsp_latency", n, (lat >= 1 && lat <= TIMEOUT) ? lat + 1 : TIMEOUT + 1);
        check("rsp_valid", {rsp1_valid, rsp0_valid}, gv);
        check("rsp_data", rsp_data, exp_d);
        check("rsp_err", rsp_err, exp_err);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            #1 check("bp_hold", {rsp1_valid, rsp0_valid, req1_ready, req0_ready, rsp_err, rsp_data},
                     {gv, 2'b00, exp_err, exp_d});
        end
        if (g == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1 check("back_idle", {busy, rsp1_valid, rsp0_valid}, 3'b000);
    endtask

    initial begin
        int g;
        bit seen;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset_outs", {busy, sort_load, req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp_err}, 0);
        check("reset_data", {rsp_data, sort_data}, 0);
        @(negedge clk);
        rst = 1'b1;
        ptr = 0;

        // Single job: entry k holds 7-k; result entry k holds k.
        req0_data  = 32'h0123_4567;
        req0_valid = 1'b1;
        g = pick();
        serve(g, 40, 1'b0, 1'b0, 0);
        check("single_result", rsp_data, 32'h7654_3210);

        // Contention: three jobs per requester, both always pending.
        req0_valid = 1'b1; req0_data = $urandom;
        req1_valid = 1'b1; req1_data = $urandom;
        for (int j = 0; j < 6; j++) begin
            g = pick();
            serve(g, $urandom_range(2, 60), 1'b0, j < 4, 0);
        end

        // Backpressure on requester 1 while requester 0 waits.
        req1_valid = 1'b1; req1_data = $urandom;
        g = pick();
        serve(g, $urandom_range(3, 30), 1'b0, 1'b0, 20);

        // Timeout with no completion, then late completion, then collision.
        g = pick();
        serve(g, 0, 1'b1, 1'b0, 0);
        req1_valid = 1'b1; req1_data = $urandom;
        g = pick();
        serve(g, TIMEOUT + 1, 1'b1, 1'b0, 0);
        req0_valid = 1'b1; req0_data = $urandom;
        g = pick();
        serve(g, TIMEOUT, 1'b0, 1'b0, 0);
        req1_valid = 1'b1; req1_data = $urandom;
        g = pick();
        serve(g, 1, 1'b0, 1'b0, 0);

        // Abort a job mid-WAIT by reset.
        req0_valid = 1'b1; req0_data = $urandom;
        eng_lat = 0;
        g = pick();
        #1 check("abort_ready", {req1_ready, req0_ready}, 2'b01);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1 check("abort_outs", {busy, sort_load, req1_ready, req0_ready, rsp1_valid, rsp0_valid, rsp_err}, 0);
        check("abort_data", {rsp_data, sort_data}, 0);
        @(negedge clk);
        rst = 1'b1;
        ptr = 0;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            #1 if (rsp0_valid || rsp1_valid || busy) seen = 1'b1;
        end
        check("no_rsp_after_abort", seen, 0);

        req0_valid = 1'b1; req0_data = $urandom;
        req1_valid = 1'b1; req1_data = $urandom;
        g = pick();
        serve(g, 30, 1'b0, 1'b0, 0);
        g = pick();
        serve(g, 12, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
